bram_responder: RTL and testbench
=================================

// Module: bram_responder
// PURPOSE
//  Dual-port synchronous BRAM model answering the ce/we/address/dout/din port pair
//  driven by mem_to_bram (port 0 = load, port 1 = store). Hosts one kernel array
//  (e.g. orig/filter/sol) in simulation and emulation. A valid/ready init stream
//  preloads it before the kernel starts; a dump stream drains it after the kernel ends.
// PARAMETERS
//  DATA_WIDTH  32    word width
//  ADDR_WIDTH  32    address port width (word addresses)
//  DEPTH       1024  number of words; valid addresses 0..DEPTH-1
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  rst         in   1           reset, asynchronous, active-low
//  ce0         in   1           port-0 enable
//  we0         in   1           port-0 write enable (qualified by ce0)
//  address0    in   ADDR_WIDTH  port-0 address
//  dout0       in   DATA_WIDTH  port-0 write data
//  din0        out  DATA_WIDTH  port-0 read data
//  ce1         in   1           port-1 enable
//  we1         in   1           port-1 write enable (qualified by ce1)
//  address1    in   ADDR_WIDTH  port-1 address
//  dout1       in   DATA_WIDTH  port-1 write data
//  din1        out  DATA_WIDTH  port-1 read data
//  init_valid  in   1           preload beat valid
//  init_ready  out  1           preload beat accepted when valid&ready
//  init_data   in   DATA_WIDTH  preload word, written to sequential addresses from 0
//  init_last   in   1           final preload beat
//  dump_req    in   1           single-cycle request to drain memory (honoured in RUN only)
//  dump_valid  out  1           dump word valid
//  dump_ready  in   1           dump word consumed when valid&ready
//  dump_data   out  DATA_WIDTH  dump word
//  dump_last   out  1           dump word is address DEPTH-1
//  running     out  1           high in RUN
//  err         out  1           sticky protocol/range error
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pointers=0, din0/din1/dump_data=0, dump_valid=0,
//   dump_last=0, running=0, err=0, init_ready=1 after release. Array contents not reset.
//  States: IDLE -> RUN on accepted beat with init_last=1 or ptr==DEPTH-1 (ptr then 0).
//   RUN -> DUMP on dump_req. DUMP -> IDLE on handshake of dump_last word.
//  IDLE: init_ready=1; each handshake writes mem[ptr]<=init_data, ptr++. Short preload
//   (init_last before DEPTH words) leaves remaining words unchanged.
//  RUN: port reads are registered, latency 1: ce=1 at cycle N -> din valid cycle N+1;
//   din holds last value while ce=0. Write (ce&we) updates mem at edge; same-port din
//   returns OLD data (read-first). Cross-port read/write same address same cycle: reader
//   gets old data. Both ports write same address: port 1 wins, err unchanged.
//  Range: address >= DEPTH -> write dropped, read returns 0, err<=1. Only low
//   clog2(DEPTH) bits index the array after the range check.
//  DUMP: ptr=0 on entry; dump_valid rises 1 cycle after entry with mem[0]; after each
//   handshake dump_valid drops 1 cycle, next word shown the cycle after (1 word per
//   2 cycles min). dump_data/dump_last stable while valid&!ready.
//  Port activity (ce0|ce1) outside RUN: ignored, err<=1. dump_req outside RUN: ignored,
//   err<=1. init_valid outside IDLE: not accepted (init_ready=0), no error.
//  err clears only on reset. Reset mid-LOAD/DUMP aborts immediately to IDLE.
// TESTING
//  T1 DEPTH=8: preload 8 words 0x10..0x17 -> running=1 after 8th beat; ce0 addr 3 ->
//   din0=0x13 next cycle, err=0.
//  T2 RUN: ce1=we1=1 addr 5 data 0xAB and ce0 addr 5 same cycle -> din0=0x15; next
//   read addr 5 -> 0xAB.
//  T3 both ports write addr 2 (0x1, 0x2) -> mem[2]=0x2; write addr 8 -> dropped, err=1.
//  T4 dump_req with dump_ready toggling 1/0 -> 8 words 0x10..0x17 (with T2 edits) in
//   order, dump_last only on 8th, data stable under backpressure, then IDLE.
//  T5 init_last on beat 3 -> RUN; mem[3..7] keep prior contents on dump.
//  T6 rst low mid-dump (word 4) -> dump_valid=0, running=0 same cycle; IDLE after release.

Source files
------------

// File: rtl/bram_responder.sv
// Dual-port synchronous BRAM model: it is preloaded over a valid/ready init stream,
// serves two read-first ports while the kernel runs, and is then drained over a dump stream.
module bram_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic                  ce1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] din1,
    input  logic                  init_valid,
    output logic                  init_ready,
    input  logic [DATA_WIDTH-1:0] init_data,
    input  logic                  init_last,
    input  logic                  dump_req,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_last,
    output logic                  running,
    output logic                  err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DUMP
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      idx0, idx1;
    logic                  in_range0, in_range1;
    logic                  wr0, wr1;
    logic                  init_fire, init_end, dump_fire;

    assign in_range0 = {1'b0, address0} < DEPTH_EXT;
    assign in_range1 = {1'b0, address1} < DEPTH_EXT;
    assign idx0      = address0[IDX_W-1:0];
    assign idx1      = address1[IDX_W-1:0];
    assign wr0       = (state == RUN) && ce0 && we0 && in_range0;
    assign wr1       = (state == RUN) && ce1 && we1 && in_range1;

    // init_ready is gated by rst so nothing is accepted while reset is held
    assign init_ready = (state == IDLE) && rst;
    assign init_fire  = init_valid && init_ready;
    assign init_end   = init_last || (ptr == LAST_IDX);
    assign dump_fire  = dump_valid && dump_ready;
    assign running    = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (init_fire && init_end) state_next = RUN;
            RUN:     if (dump_req) state_next = DUMP;
            DUMP:    if (dump_fire && dump_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Port 1 is written last, so it wins when both ports hit the same word
    always_ff @(posedge clk) begin
        if (init_fire) mem[ptr] <= init_data;
        if (wr0) mem[idx0] <= dout0;
        if (wr1) mem[idx1] <= dout1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            din0       <= '0;
            din1       <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_fire) ptr <= init_end ? '0 : ptr + 1'b1;
                end
                RUN: begin
                    if (ce0) din0 <= in_range0 ? mem[idx0] : '0;
                    if (ce1) din1 <= in_range1 ? mem[idx1] : '0;
                    if ((ce0 && !in_range0) || (ce1 && !in_range1)) err <= 1'b1;
                    if (dump_req) ptr <= '0;
                end
                DUMP: begin
                    // A bubble cycle follows every handshake before the next word appears
                    if (!dump_valid) begin
                        dump_valid <= 1'b1;
                        dump_data  <= mem[ptr];
                        dump_last  <= (ptr == LAST_IDX);
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        ptr        <= dump_last ? '0 : ptr + 1'b1;
                    end
                end
                default: ;
            endcase
            if ((state != RUN) && (ce0 || ce1 || dump_req)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_responder.sv
// Directed bench for bram_responder at DEPTH=8: preload, port reads/writes, range errors,
// dump with backpressure, short preload and reset during dump.
module tb_bram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce0, we0, ce1, we1;
    logic [31:0] address0, address1, dout0, dout1;
    logic [31:0] din0, din1;
    logic        init_valid, init_ready, init_last;
    logic [31:0] init_data;
    logic        dump_req, dump_valid, dump_ready, dump_last;
    logic [31:0] dump_data;
    logic        running, err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_mem [8];

    bram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0), .din0(din0),
        .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1), .din1(din1),
        .init_valid(init_valid), .init_ready(init_ready), .init_data(init_data),
        .init_last(init_last), .dump_req(dump_req), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
        .running(running), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input logic [31:0] base, input bit use_last);
        for (int i = 0; i < n; i++) begin
            init_valid = 1'b1;
            init_data  = base + 32'(i);
            init_last  = use_last && (i == n - 1);
            checks++;
            if (init_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL preload_ready beat %0d: got %b want 1", i, init_ready);
            end
            cyc();
        end
        init_valid = 1'b0;
        init_last  = 1'b0;
    endtask

    task automatic read0(input logic [31:0] addr, input logic [31:0] want, input string name);
        ce0 = 1'b1; we0 = 1'b0; address0 = addr;
        cyc();
        ce0 = 1'b0;
        checks++;
        if (din0 !== want) begin
            errors++;
            $display("[TB] FAIL %s: din0 got %h want %h", name, din0, want);
        end
    endtask

    task automatic run_dump(input int stop_at);
        int  idx;
        int  cycles;
        logic rdy;
        idx = 0; cycles = 0; rdy = 1'b0;
        dump_req = 1'b1;
        cyc();
        dump_req = 1'b0;
        while (1) begin
            if (dump_valid) begin
                checks++;
                if (dump_data !== exp_mem[idx]) begin
                    errors++;
                    $display("[TB] FAIL dump_data word %0d: got %h want %h", idx, dump_data, exp_mem[idx]);
                end
                checks++;
                if (dump_last !== (idx == 7)) begin
                    errors++;
                    $display("[TB] FAIL dump_last word %0d: got %b want %b", idx, dump_last, idx == 7);
                end
                if (idx == stop_at) break;
            end
            if (idx >= stop_at) break;
            dump_ready = rdy;
            if (dump_valid && rdy) idx++;
            cyc();
            rdy = ~rdy;
            cycles++;
            if (cycles > 200) begin
                errors++;
                $display("[TB] FAIL dump_timeout: got %0d words want %0d", idx, stop_at);
                break;
            end
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if ({dump_valid, dump_last, running, err} !== 4'b0000 || din0 !== 32'h0 || din1 !== 32'h0
            || dump_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b l=%b r=%b e=%b d0=%h d1=%h dd=%h want zeros",
                     dump_valid, dump_last, running, err, din0, din1, dump_data);
        end
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (init_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_init_ready: got %b want 1", init_ready);
        end
    endtask

    task automatic test_preload_read();
        preload(8, 32'h10, 1'b0);
        for (int i = 0; i < 8; i++) exp_mem[i] = 32'h10 + 32'(i);
        checks++;
        if (running !== 1'b1 || init_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_entry: running=%b init_ready=%b want 1/0", running, init_ready);
        end
        read0(32'd3, 32'h13, "read_addr3");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_err: got %b want 0", err);
        end
        cyc();
        checks++;
        if (din0 !== 32'h13) begin
            errors++;
            $display("[TB] FAIL din0_hold: got %h want 13", din0);
        end
    endtask

    task automatic test_cross_port();
        ce1 = 1'b1; we1 = 1'b1; address1 = 32'd5; dout1 = 32'hAB;
        ce0 = 1'b1; we0 = 1'b0; address0 = 32'd5;
        cyc();
        ce0 = 1'b0; ce1 = 1'b0; we1 = 1'b0;
        exp_mem[5] = 32'hAB;
        checks++;
        if (din0 !== 32'h15 || din1 !== 32'h15) begin
            errors++;
            $display("[TB] FAIL read_first: din0=%h din1=%h want 15/15", din0, din1);
        end
        read0(32'd5, 32'hAB, "read_after_write");
    endtask

    task automatic test_write_collision_range();
        ce0 = 1'b1; we0 = 1'b1; address0 = 32'd2; dout0 = 32'h1;
        ce1 = 1'b1; we1 = 1'b1; address1 = 32'd2; dout1 = 32'h2;
        cyc();
        ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; we1 = 1'b0;
        exp_mem[2] = 32'h2;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collision_err: got %b want 0", err);
        end
        read0(32'd2, 32'h2, "collision_port1_wins");
        ce0 = 1'b1; we0 = 1'b1; address0 = 32'd8; dout0 = 32'hEE;
        cyc();
        ce0 = 1'b0; we0 = 1'b0;
        checks++;
        if (err !== 1'b1 || din0 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL out_of_range: err=%b din0=%h want 1/0", err, din0);
        end
        read0(32'd0, 32'h10, "range_write_dropped");
    endtask

    task automatic test_dump();
        run_dump(8);
        checks++;
        if (running !== 1'b0 || init_ready !== 1'b1 || dump_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dump_to_idle: running=%b init_ready=%b valid=%b want 0/1/0",
                     running, init_ready, dump_valid);
        end
    endtask

    task automatic test_short_preload();
        preload(3, 32'h20, 1'b1);
        exp_mem[0] = 32'h20; exp_mem[1] = 32'h21; exp_mem[2] = 32'h22;
        checks++;
        if (running !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL short_preload: running=%b err=%b want 1/1", running, err);
        end
        run_dump(8);
    endtask

    task automatic test_reset_mid_dump();
        preload(1, 32'h30, 1'b1);
        exp_mem[0] = 32'h30;
        run_dump(4);
        rst = 1'b0;
        #1;
        checks++;
        if (dump_valid !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abort: valid=%b running=%b want 0/0", dump_valid, running);
        end
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if (init_ready !== 1'b1 || running !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: init_ready=%b running=%b err=%b want 1/0/0",
                     init_ready, running, err);
        end
    endtask

    task automatic test_idle_activity();
        ce0 = 1'b1; address0 = 32'd1;
        cyc();
        ce0 = 1'b0;
        checks++;
        if (err !== 1'b1 || din0 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL idle_port_access: err=%b din0=%h want 1/0", err, din0);
        end
        preload(1, 32'h40, 1'b1);
        read0(32'd0, 32'h40, "preload_ptr_restart");
        read0(32'd4, 32'h14, "preload_no_side_write");
    endtask

    initial begin
        ce0 = 0; we0 = 0; ce1 = 0; we1 = 0;
        address0 = 0; address1 = 0; dout0 = 0; dout1 = 0;
        init_valid = 0; init_data = 0; init_last = 0;
        dump_req = 0; dump_ready = 0;
        test_reset();
        test_preload_read();
        test_cross_port();
        test_write_collision_range();
        test_dump();
        test_short_preload();
        test_reset_mid_dump();
        test_idle_activity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
